mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the processor's single memory port between the instruction-fetch path and the data (load/store) path. It produces the `i_odv` / `d_odv` completion strobes consumed by the instruction-sequencing controller. Each port uses a request/hold handshake. Contention is resolved with data-first, alternating priority, and a watchdog counter aborts memory accesses that never acknowledge.

## Interface
Parameters:
- `AW`, 16, address width
- `DW`, 16, data width
- `TIMEOUT`, 255, max cycles `m_req` is held without `m_ack` before abort (1..255)

Ports:
- `g_clk`  in  1  system clock, all state on rising edge
- `g_clr`  in  1  reset, asynchronous, active-low
- `i_req`  in  1  instruction-fetch request, level, held until `i_odv`
- `i_addr`  in  AW  fetch address, stable while `i_req`
- `i_dout`  out  DW  fetched word, valid when `i_odv`
- `i_odv`  out  1  fetch complete, one-cycle pulse
- `d_req`  in  1  data request, level, held until `d_odv`
- `d_we`  in  1  1 = store, 0 = load, stable while `d_req`
- `d_addr`  in  AW  data address
- `d_din`  in  DW  store data
- `d_dout`  out  DW  load data, valid when `d_odv`
- `d_odv`  out  1  data access complete (load or store), one-cycle pulse
- `m_req`  out  1  memory request, level
- `m_we`  out  1  memory write enable
- `m_addr`  out  AW  memory address
- `m_wdata`  out  DW  memory write data
- `m_rdata`  in  DW  memory read data, valid with `m_ack`
- `m_ack`  in  1  memory acknowledge, one cycle
- `busy`  out  1  high in any state other than IDLE
- `err`  out  1  pulses with `i_odv`/`d_odv` when that access timed out

## Operation
- The FSM has three states: IDLE, ACCESS, DONE.
- **IDLE:**
  - No request: remain in IDLE.
  - Only `i_req`: grant I.
  - Only `d_req`: grant D.
  - Both: grant the port that did not win the last contested grant. `last_win` resets to I, so the first contest goes to D.
  - On a grant, register address, we and wdata into the `m_*` outputs. Go to ACCESS.
- **ACCESS:**
  - `m_req` = 1. The watchdog counter increments each cycle.
  - `m_ack` = 1: capture `m_rdata` into the granted port's dout (loads and fetches only; stores leave `d_dout` unchanged). Go to DONE.
  - Counter reaches `TIMEOUT` with `m_ack` = 0: set the err flag. Force the granted dout to 0 (store: unchanged). Go to DONE.
- **DONE:**
  - `m_req` = 0. Assert the granted port's odv. Assert `err` if the flag is set.
  - Unconditionally go to IDLE. Clear the counter and the err flag.
- `i_dout` / `d_dout` hold their last value until the next completion on that port.
- `m_ack` in IDLE or DONE is ignored.
- `m_ack` in the same cycle the counter hits `TIMEOUT` counts as a normal completion; `err` stays 0.
- Requesters are registered: they drop `req` on the edge that samples odv = 1, so IDLE never re-grants a finished request.
- Reset (any time, including mid-ACCESS):
  - State goes to IDLE; `last_win` goes to I; the counter clears.
  - All outputs go to 0: `m_req`, `m_we`, `m_addr`, `m_wdata`, `i_dout`, `d_dout`, `i_odv`, `d_odv`, `err`, `busy`.
  - The in-flight access is dropped without an odv.

## Timing
- Request sampled high at edge E0 → `m_req` high from E0.
- `m_ack` sampled at edge Ek → DONE after Ek: odv/dout valid for exactly one cycle, `m_req` already low.
- Minimum request-to-odv latency is 2 cycles (ack in the first ACCESS cycle).
- Timeout completion: odv appears `TIMEOUT`+1 cycles after entering ACCESS.
- Back-to-back accesses: one access per 3 cycles minimum (IDLE–ACCESS–DONE). There is one IDLE cycle between accesses.
- `m_addr` / `m_we` / `m_wdata` are stable for the whole ACCESS interval. They retain their value in IDLE/DONE; `m_req` qualifies them.

## Structure
- Shared package `mem_arb_pkg`:
  - State encodings IDLE/ACCESS/DONE.
  - Grant IDs `GNT_I` / `GNT_D`.
  - Default `AW`/`DW` constants shared with the controller.
- One sub-module: `arb_watchdog`, an 8-bit counter with clear/enable inputs and an `expired` output compared against `TIMEOUT`.

## Test plan
- **Fetch read:** `i_req` with `i_addr`=0x0010; memory acks on the 1st ACCESS cycle with 0xBEEF → `i_odv` pulses 2 cycles after request, `i_dout`=0xBEEF, `err`=0.
- **Simultaneous requests:** `i_req`+`d_req` asserted together repeatedly → grant order D, I, D, I. `m_addr` alternates between `d_addr` and `i_addr`, and each odv pulses once.
- **Store:** `d_we`=1, `d_addr`=0x0200, `d_din`=0x1234, ack after 3 cycles → `m_we`=1, `m_wdata`=0x1234 throughout ACCESS. `d_odv` pulses, `d_dout` unchanged.
- **Timeout:** `TIMEOUT`=4, `d_req` load, no ack → `d_odv` and `err` pulse together 5 cycles after entering ACCESS. `d_dout`=0, `m_req` low in DONE.
- **Ack on timeout boundary:** `m_ack` in the cycle the counter hits `TIMEOUT` → normal completion with data captured, `err`=0.
- **Reset mid-access:** assert `g_clr` low during ACCESS → immediately `m_req`=0, `busy`=0, all outputs 0, no odv. The next contested request is granted to D.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
// State and grant encodings, default bus widths.
package mem_arb_pkg;

  localparam int ARB_AW = 16;
  localparam int ARB_DW = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

endpackage

// File: rtl/arb_watchdog.sv
// Access watchdog: 8-bit cycle counter that
// flags expiry when it reaches TIMEOUT.
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == 8'(TIMEOUT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data paths
// with alternating priority and a watchdog abort.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          AW      = ARB_AW,
  parameter int          DW      = ARB_DW,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          g_clk,
  input  logic          g_clr,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_dout,
  output logic          i_odv,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_din,
  output logic [DW-1:0] d_dout,
  output logic          d_odv,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          busy,
  output logic          err
);

  state_e        state_q;
  gnt_e          gnt_q;
  gnt_e          last_win_q;
  logic          m_req_q;
  logic          m_we_q;
  logic [AW-1:0] m_addr_q;
  logic [DW-1:0] m_wdata_q;
  logic [DW-1:0] i_dout_q;
  logic [DW-1:0] d_dout_q;
  logic          i_odv_q;
  logic          d_odv_q;
  logic          err_q;
  logic          busy_q;

  logic contested;
  logic pick_d;
  logic expired;

  assign contested = i_req & d_req;
  assign pick_d    = d_req & (~i_req | (last_win_q == GNT_I));

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk_i    (g_clk),
    .rst_ni   (g_clr),
    .clr_i    (state_q != ACCESS),
    .en_i     (state_q == ACCESS),
    .expired_o(expired)
  );

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      state_q    <= IDLE;
      gnt_q      <= GNT_I;
      last_win_q <= GNT_I;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      i_dout_q   <= '0;
      d_dout_q   <= '0;
      i_odv_q    <= 1'b0;
      d_odv_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      i_odv_q <= 1'b0;
      d_odv_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
            state_q <= ACCESS;
            m_req_q <= 1'b1;
            busy_q  <= 1'b1;
            gnt_q   <= pick_d ? GNT_D : GNT_I;
            if (contested) begin
              last_win_q <= pick_d ? GNT_D : GNT_I;
            end
            m_we_q   <= pick_d & d_we;
            m_addr_q <= pick_d ? d_addr : i_addr;
            if (pick_d) begin
              m_wdata_q <= d_din;
            end
          end
        end
        ACCESS: begin
          // ack on the expiry cycle still wins
          if (m_ack || expired) begin
            state_q <= DONE;
            m_req_q <= 1'b0;
            err_q   <= ~m_ack;
            if (gnt_q == GNT_I) begin
              i_odv_q  <= 1'b1;
              i_dout_q <= m_ack ? m_rdata : '0;
            end else begin
              d_odv_q <= 1'b1;
              if (!m_we_q) begin
                d_dout_q <= m_ack ? m_rdata : '0;
              end
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          m_req_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_dout  = i_dout_q;
  assign d_dout  = d_dout_q;
  assign i_odv   = i_odv_q;
  assign d_odv   = d_odv_q;
  assign err     = err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// Completions are checked against a queue of expected results.
module tb_mem_port_arbiter;

  logic        g_clk;
  logic        g_clr;
  logic        i_req;
  logic [15:0] i_addr;
  logic [15:0] i_dout;
  logic        i_odv;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_din;
  logic [15:0] d_dout;
  logic        d_odv;
  logic        m_req;
  logic        m_we;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;
  logic        m_ack;
  logic        busy;
  logic        err;

  mem_port_arbiter #(
    .AW(16),
    .DW(16),
    .TIMEOUT(4)
  ) dut (
    .g_clk  (g_clk),
    .g_clr  (g_clr),
    .i_req  (i_req),
    .i_addr (i_addr),
    .i_dout (i_dout),
    .i_odv  (i_odv),
    .d_req  (d_req),
    .d_we   (d_we),
    .d_addr (d_addr),
    .d_din  (d_din),
    .d_dout (d_dout),
    .d_odv  (d_odv),
    .m_req  (m_req),
    .m_we   (m_we),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .m_ack  (m_ack),
    .busy   (busy),
    .err    (err)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  typedef struct {
    bit          is_d;
    logic [15:0] dout;
    bit          err;
  } exp_t;

  exp_t sbq[$];
  int   checks;
  int   errors;
  logic [15:0] exp_i_dout;
  logic [15:0] exp_d_dout;
  bit   mdl_last_d;

  task automatic wait_mreq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge g_clk);
      if (m_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    g_clr = 1'b0;
    repeat (2) @(negedge g_clk);
    checks++;
    if ({m_req, m_we, m_addr, m_wdata, i_dout, d_dout,
         i_odv, d_odv, err, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got req=%b we=%b a=%h w=%h id=%h dd=%h busy=%b exp all 0",
               m_req, m_we, m_addr, m_wdata, i_dout, d_dout, busy);
    end
    g_clr = 1'b1;
    @(negedge g_clk);
    checks++;
    if (busy !== 1'b0 || m_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b req=%b exp 0", busy, m_req);
    end
  endtask

  task automatic test_fetch;
    bit ok;
    exp_t e;
    i_req  = 1'b1;
    i_addr = 16'h0010;
    wait_mreq(ok);
    checks++;
    if (!ok || m_addr !== 16'h0010 || m_we !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fetch_grant got ok=%b addr=%h we=%b busy=%b exp addr 0010 we 0",
               ok, m_addr, m_we, busy);
    end
    m_ack   = 1'b1;
    m_rdata = 16'hBEEF;
    sbq.push_back('{is_d: 1'b0, dout: 16'hBEEF, err: 1'b0});
    exp_i_dout = 16'hBEEF;
    @(negedge g_clk);
    m_ack = 1'b0;
    checks++;
    if (sbq.size() == 0 || i_odv !== 1'b1) begin
      errors++;
      $display("FAIL fetch_odv got i_odv=%b exp 1", i_odv);
    end else begin
      e = sbq.pop_front();
      checks++;
      if (i_dout !== e.dout || err !== e.err || d_odv !== 1'b0 || m_req !== 1'b0) begin
        errors++;
        $display("FAIL fetch_data got dout=%h err=%b d_odv=%b req=%b exp %h 0 0 0",
                 i_dout, err, d_odv, m_req, e.dout);
      end
    end
    i_req = 1'b0;
    @(negedge g_clk);
    checks++;
    if (i_odv !== 1'b0 || busy !== 1'b0 || i_dout !== exp_i_dout) begin
      errors++;
      $display("FAIL fetch_idle got odv=%b busy=%b dout=%h exp 0 0 %h",
               i_odv, busy, i_dout, exp_i_dout);
    end
  endtask

  task automatic test_simultaneous;
    bit ok;
    bit win_d;
    exp_t e;
    logic [15:0] want_addr;
    i_addr = 16'h0100;
    d_addr = 16'h0300;
    d_we   = 1'b0;
    i_req  = 1'b1;
    d_req  = 1'b1;
    for (int n = 0; n < 4; n++) begin
      win_d = d_req && (!i_req || !mdl_last_d);
      if (i_req && d_req) mdl_last_d = win_d;
      want_addr = win_d ? d_addr : i_addr;
      wait_mreq(ok);
      checks++;
      if (!ok || m_addr !== want_addr || win_d !== (n % 2 == 0)) begin
        errors++;
        $display("FAIL sim_grant%0d got ok=%b addr=%h exp addr %h d=%b",
                 n, ok, m_addr, want_addr, (n % 2 == 0));
      end
      m_ack   = 1'b1;
      m_rdata = 16'hA000 + 16'(n);
      sbq.push_back('{is_d: win_d, dout: m_rdata, err: 1'b0});
      @(negedge g_clk);
      m_ack = 1'b0;
      e = sbq.pop_front();
      checks++;
      if ((e.is_d ? d_odv : i_odv) !== 1'b1 ||
          (e.is_d ? i_odv : d_odv) !== 1'b0 ||
          (e.is_d ? d_dout : i_dout) !== e.dout || err !== 1'b0) begin
        errors++;
        $display("FAIL sim_done%0d got i_odv=%b d_odv=%b id=%h dd=%h exp d=%b dout=%h",
                 n, i_odv, d_odv, i_dout, d_dout, e.is_d, e.dout);
      end
      if (e.is_d) begin
        exp_d_dout = e.dout;
        d_req = 1'b0;
      end else begin
        exp_i_dout = e.dout;
        i_req = 1'b0;
      end
      @(negedge g_clk);
      checks++;
      if (busy !== 1'b0 || i_odv !== 1'b0 || d_odv !== 1'b0) begin
        errors++;
        $display("FAIL sim_gap%0d got busy=%b odv=%b%b exp 0 00", n, busy, i_odv, d_odv);
      end
      if (n < 2) begin
        if (e.is_d) begin
          d_addr = d_addr + 16'h0010;
          d_req  = 1'b1;
        end else begin
          i_addr = i_addr + 16'h0010;
          i_req  = 1'b1;
        end
      end
    end
  endtask

  task automatic test_store;
    bit ok;
    d_we   = 1'b1;
    d_addr = 16'h0200;
    d_din  = 16'h1234;
    d_req  = 1'b1;
    wait_mreq(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL store_grant got no m_req exp m_req 1");
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (m_req !== 1'b1 || m_we !== 1'b1 || m_wdata !== 16'h1234 || m_addr !== 16'h0200) begin
        errors++;
        $display("FAIL store_hold%0d got req=%b we=%b w=%h a=%h exp 1 1 1234 0200",
                 k, m_req, m_we, m_wdata, m_addr);
      end
      if (k < 3) @(negedge g_clk);
    end
    m_ack   = 1'b1;
    m_rdata = 16'hDEAD;
    sbq.push_back('{is_d: 1'b1, dout: exp_d_dout, err: 1'b0});
    @(negedge g_clk);
    m_ack = 1'b0;
    begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      if (d_odv !== 1'b1 || d_dout !== e.dout || err !== e.err || i_odv !== 1'b0) begin
        errors++;
        $display("FAIL store_done got odv=%b dout=%h err=%b exp 1 %h 0",
                 d_odv, d_dout, err, e.dout);
      end
    end
    d_req = 1'b0;
    d_we  = 1'b0;
    @(negedge g_clk);
  endtask

  task automatic test_timeout;
    bit ok;
    int cyc;
    exp_t e;
    d_addr = 16'h0400;
    d_req  = 1'b1;
    sbq.push_back('{is_d: 1'b1, dout: 16'h0000, err: 1'b1});
    wait_mreq(ok);
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge g_clk);
      cyc++;
      if (d_odv) break;
    end
    e = sbq.pop_front();
    exp_d_dout = e.dout;
    checks++;
    if (!ok || d_odv !== 1'b1 || cyc != 5) begin
      errors++;
      $display("FAIL timeout_latency got ok=%b odv=%b cycles=%0d exp 5", ok, d_odv, cyc);
    end
    checks++;
    if (err !== e.err || d_dout !== e.dout || m_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_done got err=%b dout=%h req=%b exp 1 0000 0", err, d_dout, m_req);
    end
    d_req = 1'b0;
    @(negedge g_clk);
    checks++;
    if (err !== 1'b0 || d_odv !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse got err=%b odv=%b exp 0 0", err, d_odv);
    end
  endtask

  task automatic test_boundary;
    bit ok;
    exp_t e;
    d_addr = 16'h0500;
    d_req  = 1'b1;
    wait_mreq(ok);
    repeat (4) @(negedge g_clk);
    checks++;
    if (!ok || m_req !== 1'b1 || d_odv !== 1'b0) begin
      errors++;
      $display("FAIL boundary_wait got ok=%b req=%b odv=%b exp 1 1 0", ok, m_req, d_odv);
    end
    m_ack   = 1'b1;
    m_rdata = 16'h5A5A;
    sbq.push_back('{is_d: 1'b1, dout: 16'h5A5A, err: 1'b0});
    @(negedge g_clk);
    m_ack = 1'b0;
    e = sbq.pop_front();
    exp_d_dout = e.dout;
    checks++;
    if (d_odv !== 1'b1 || d_dout !== e.dout || err !== e.err) begin
      errors++;
      $display("FAIL boundary_done got odv=%b dout=%h err=%b exp 1 %h 0",
               d_odv, d_dout, err, e.dout);
    end
    d_req = 1'b0;
    @(negedge g_clk);
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit seen;
    exp_t e;
    d_addr = 16'h0600;
    d_req  = 1'b1;
    wait_mreq(ok);
    @(negedge g_clk);
    g_clr = 1'b0;
    #1;
    checks++;
    if (!ok || {m_req, m_we, m_addr, m_wdata, i_dout, d_dout,
                i_odv, d_odv, err, busy} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got ok=%b req=%b busy=%b dd=%h id=%h exp all 0",
               ok, m_req, busy, d_dout, i_dout);
    end
    d_req = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge g_clk);
      if (i_odv || d_odv || busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midreset_quiet got odv/busy during reset exp none");
    end
    g_clr = 1'b1;
    exp_i_dout = 16'h0000;
    exp_d_dout = 16'h0000;
    @(negedge g_clk);
    i_addr = 16'h0700;
    d_addr = 16'h0800;
    i_req  = 1'b1;
    d_req  = 1'b1;
    wait_mreq(ok);
    checks++;
    if (!ok || m_addr !== 16'h0800) begin
      errors++;
      $display("FAIL midreset_contest got ok=%b addr=%h exp 0800", ok, m_addr);
    end
    m_ack   = 1'b1;
    m_rdata = 16'h1111;
    sbq.push_back('{is_d: 1'b1, dout: 16'h1111, err: 1'b0});
    @(negedge g_clk);
    m_ack = 1'b0;
    e = sbq.pop_front();
    checks++;
    if (d_odv !== 1'b1 || d_dout !== e.dout || i_dout !== exp_i_dout) begin
      errors++;
      $display("FAIL midreset_d got odv=%b dd=%h id=%h exp 1 %h %h",
               d_odv, d_dout, i_dout, e.dout, exp_i_dout);
    end
    d_req = 1'b0;
    wait_mreq(ok);
    m_ack   = 1'b1;
    m_rdata = 16'h2222;
    sbq.push_back('{is_d: 1'b0, dout: 16'h2222, err: 1'b0});
    @(negedge g_clk);
    m_ack = 1'b0;
    e = sbq.pop_front();
    checks++;
    if (!ok || i_odv !== 1'b1 || i_dout !== e.dout) begin
      errors++;
      $display("FAIL midreset_i got ok=%b odv=%b id=%h exp 1 1 %h", ok, i_odv, i_dout, e.dout);
    end
    i_req = 1'b0;
    @(negedge g_clk);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    mdl_last_d = 1'b0;
    exp_i_dout = 16'h0000;
    exp_d_dout = 16'h0000;
    g_clr   = 1'b0;
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_din   = '0;
    m_rdata = '0;
    m_ack   = 1'b0;
    test_reset();
    test_fetch();
    test_simultaneous();
    test_store();
    test_timeout();
    test_boundary();
    test_reset_mid();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left exp 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
